// File: rtl/call_stack_pkg.sv
// -----------------------------------------------------------------------------
// call_stack_pkg
// Shared instruction-header constants for the return-address stack. The
// instruction decoder and call_stack both import this package so that the
// stack_control encoding and the stack_flags bit positions stay in one place.
//
// Contents:
//   stack_op_e   - 2-bit {PUSH, POP} stack_control encoding
//   STACK_FULL   - bit index of FULL in stack_flags
//   STACK_EMPTY  - bit index of EMPTY in stack_flags
// -----------------------------------------------------------------------------
package call_stack_pkg;

   typedef enum logic [1:0] {
      STACK_IDLE = 2'b00,
      STACK_POP  = 2'b01,
      STACK_PUSH = 2'b10,
      STACK_REPL = 2'b11
   } stack_op_e;

   localparam int STACK_FULL  = 1;
   localparam int STACK_EMPTY = 0;

endpackage : call_stack_pkg

// File: rtl/call_stack.sv
// -----------------------------------------------------------------------------
// call_stack
// Hardware return-address stack (LIFO) that sits behind the instruction
// decoder. CLL pushes the return PC, RET pops it, and a replace operation
// overwrites the top entry in place. The decoder gates CLL/RET with
// stack_flags, but the stack still protects itself: it never wraps, and it
// records illegal pushes and pops in sticky error flags.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   stack_control  {PUSH, POP}: 10 push, 01 pop, 11 replace top, 00 idle
//   push_data      return address written on push / replace
//   top_data       current top entry, 0 when empty
//   stack_flags    {FULL, EMPTY}, combinational from the registered count
//   count          current occupancy, 0..DEPTH
//   overflow       sticky: push attempted while full
//   underflow      sticky: pop attempted while empty
//   err_clr        synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module call_stack
   import call_stack_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            stack_control,
   input  logic [ADDR_WIDTH-1:0] push_data,
   output logic [ADDR_WIDTH-1:0] top_data,
   output logic [1:0]            stack_flags,
   output logic [PTR_WIDTH-1:0]  count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int IDX_WIDTH = $clog2(DEPTH);

   logic [ADDR_WIDTH-1:0] mem [DEPTH];

   logic                  full;
   logic                  empty;
   logic [PTR_WIDTH-1:0]  top_ptr;
   logic [IDX_WIDTH-1:0]  top_idx;
   logic [IDX_WIDTH-1:0]  push_idx;

   logic                  do_write;
   logic [IDX_WIDTH-1:0]  wr_idx;
   logic [PTR_WIDTH-1:0]  count_next;
   logic                  set_ovf;
   logic                  set_unf;

   assign full  = (count == PTR_WIDTH'(DEPTH));
   assign empty = (count == '0);

   assign stack_flags[STACK_FULL]  = full;
   assign stack_flags[STACK_EMPTY] = empty;

   // Only meaningful when not empty / not full respectively; both are
   // qualified below, so the truncation never selects a wrapped slot.
   assign top_ptr  = count - PTR_WIDTH'(1);
   assign top_idx  = top_ptr[IDX_WIDTH-1:0];
   assign push_idx = count[IDX_WIDTH-1:0];

   assign top_data = empty ? '0 : mem[top_idx];

   // Next-state decode. Any undefined stack_control falls into default and
   // behaves as idle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves one unassigned and infers a latch.
      do_write   = 1'b0;
      wr_idx     = push_idx;
      count_next = count;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;

      case (stack_op_e'(stack_control))
         STACK_PUSH: begin
            if (full) begin
               set_ovf = 1'b1;
            end else begin
               do_write   = 1'b1;
               count_next = count + PTR_WIDTH'(1);
            end
         end
         STACK_POP: begin
            if (empty) begin
               set_unf = 1'b1;
            end else begin
               count_next = top_ptr;
            end
         end
         STACK_REPL: begin
            // Replace on an empty stack degenerates to a push into slot 0;
            // replace on a full stack is legal and raises no error.
            do_write = 1'b1;
            if (empty) begin
               count_next = PTR_WIDTH'(1);
            end else begin
               wr_idx = top_idx;
            end
         end
         default: ;
      endcase
   end

   // Pointer and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of block order.
         count     <= count_next;
         // A new error on the same edge as err_clr wins over the clear.
         overflow  <= set_ovf | (overflow  & ~err_clr);
         underflow <= set_unf | (underflow & ~err_clr);
      end
   end

   // NOTE: the storage array is deliberately not reset; count alone decides
   // which entries are valid, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_idx] <= push_data;
      end
   end

endmodule : call_stack

// File: tb/tb_call_stack.sv
// -----------------------------------------------------------------------------
// tb_call_stack
// Directed self-checking bench for call_stack (ADDR_WIDTH=8, DEPTH=8).
// Each scenario task drives stimulus and compares outputs against
// hand-computed values; a summary line closes the run.
// -----------------------------------------------------------------------------
module tb_call_stack;
   import call_stack_pkg::*;

   localparam int ADDR_WIDTH = 8;
   localparam int DEPTH      = 8;
   localparam int PTR_WIDTH  = $clog2(DEPTH) + 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [1:0]            stack_control = STACK_IDLE;
   logic [ADDR_WIDTH-1:0] push_data = '0;
   logic [ADDR_WIDTH-1:0] top_data;
   logic [1:0]            stack_flags;
   logic [PTR_WIDTH-1:0]  count;
   logic                  overflow;
   logic                  underflow;
   logic                  err_clr = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   call_stack #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stack_control (stack_control),
      .push_data     (push_data),
      .top_data      (top_data),
      .stack_flags   (stack_flags),
      .count         (count),
      .overflow      (overflow),
      .underflow     (underflow),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   // Drive one operation across one rising edge; outputs are observed 1 ns
   // after that edge, once the registered state has settled.
   task automatic step(input logic [1:0] ctrl, input logic [7:0] data,
                       input logic clr);
      @(negedge clk);
      stack_control = ctrl;
      push_data     = data;
      err_clr       = clr;
      @(posedge clk);
      #1;
      stack_control = STACK_IDLE;
      err_clr       = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (3) step(STACK_IDLE, 8'h00, 1'b0);
      tests_run++;
      if (stack_flags !== 2'b01) begin
         tests_failed++;
         $display("FAIL reset_flags got %b exp %b", stack_flags, 2'b01);
      end
      tests_run++;
      if (count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_count got %0d exp %0d", count, 0);
      end
      tests_run++;
      if (top_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_top got %h exp %h", top_data, 8'h00);
      end
      tests_run++;
      if ({overflow, underflow} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_errs got %b exp %b", {overflow, underflow}, 2'b00);
      end
   endtask

   task automatic test_push_pop();
      logic [7:0] exp_top [3];
      exp_top[0] = 8'h20;
      exp_top[1] = 8'h10;
      exp_top[2] = 8'h00;
      apply_reset();
      step(STACK_PUSH, 8'h10, 1'b0);
      tests_run++;
      if (top_data !== 8'h10 || count !== 4'd1) begin
         tests_failed++;
         $display("FAIL push1 got top=%h cnt=%0d exp top=10 cnt=1", top_data, count);
      end
      step(STACK_PUSH, 8'h20, 1'b0);
      step(STACK_PUSH, 8'h30, 1'b0);
      tests_run++;
      if (count !== 4'd3 || top_data !== 8'h30 || stack_flags !== 2'b00) begin
         tests_failed++;
         $display("FAIL push3 got cnt=%0d top=%h flags=%b exp cnt=3 top=30 flags=00",
                  count, top_data, stack_flags);
      end
      for (int i = 0; i < 3; i++) begin
         step(STACK_POP, 8'h00, 1'b0);
         tests_run++;
         if (top_data !== exp_top[i] || count !== PTR_WIDTH'(2 - i)) begin
            tests_failed++;
            $display("FAIL pop%0d got top=%h cnt=%0d exp top=%h cnt=%0d",
                     i, top_data, count, exp_top[i], 2 - i);
         end
      end
      tests_run++;
      if (stack_flags !== 2'b01 || underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL pop_empty got flags=%b unf=%b exp flags=01 unf=0",
                  stack_flags, underflow);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         step(STACK_PUSH, 8'(i), 1'b0);
      end
      tests_run++;
      if (stack_flags !== 2'b10 || count !== 4'd8 || top_data !== 8'h08) begin
         tests_failed++;
         $display("FAIL full got flags=%b cnt=%0d top=%h exp flags=10 cnt=8 top=08",
                  stack_flags, count, top_data);
      end
      step(STACK_PUSH, 8'hFF, 1'b0);
      tests_run++;
      if (overflow !== 1'b1 || count !== 4'd8 || top_data !== 8'h08) begin
         tests_failed++;
         $display("FAIL ovf_push got ovf=%b cnt=%0d top=%h exp ovf=1 cnt=8 top=08",
                  overflow, count, top_data);
      end
      step(STACK_IDLE, 8'h00, 1'b1);
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_clr got %b exp %b", overflow, 1'b0);
      end
      // Replace while full: legal, no error, count unchanged.
      step(STACK_REPL, 8'hAA, 1'b0);
      tests_run++;
      if (overflow !== 1'b0 || count !== 4'd8 || top_data !== 8'hAA) begin
         tests_failed++;
         $display("FAIL repl_full got ovf=%b cnt=%0d top=%h exp ovf=0 cnt=8 top=AA",
                  overflow, count, top_data);
      end
      // Entry below the top must be intact after the replace.
      step(STACK_POP, 8'h00, 1'b0);
      tests_run++;
      if (top_data !== 8'h07 || count !== 4'd7) begin
         tests_failed++;
         $display("FAIL pop_after_repl got top=%h cnt=%0d exp top=07 cnt=7",
                  top_data, count);
      end
   endtask

   task automatic test_underflow();
      apply_reset();
      step(STACK_POP, 8'h00, 1'b0);
      tests_run++;
      if (underflow !== 1'b1 || count !== 4'd0 || top_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL unf_pop got unf=%b cnt=%0d top=%h exp unf=1 cnt=0 top=00",
                  underflow, count, top_data);
      end
      step(STACK_POP, 8'h00, 1'b1);
      tests_run++;
      if (underflow !== 1'b1 || count !== 4'd0) begin
         tests_failed++;
         $display("FAIL unf_clr_collide got unf=%b cnt=%0d exp unf=1 cnt=0",
                  underflow, count);
      end
      step(STACK_IDLE, 8'h00, 1'b1);
      tests_run++;
      if (underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL unf_clr got %b exp %b", underflow, 1'b0);
      end
   endtask

   task automatic test_replace();
      apply_reset();
      step(STACK_PUSH, 8'h40, 1'b0);
      step(STACK_REPL, 8'h55, 1'b0);
      tests_run++;
      if (count !== 4'd1 || top_data !== 8'h55) begin
         tests_failed++;
         $display("FAIL repl_top got cnt=%0d top=%h exp cnt=1 top=55", count, top_data);
      end
      step(STACK_POP, 8'h00, 1'b0);
      step(STACK_REPL, 8'h66, 1'b0);
      tests_run++;
      if (count !== 4'd1 || top_data !== 8'h66 || stack_flags !== 2'b00) begin
         tests_failed++;
         $display("FAIL repl_empty got cnt=%0d top=%h flags=%b exp cnt=1 top=66 flags=00",
                  count, top_data, stack_flags);
      end
      tests_run++;
      if ({overflow, underflow} !== 2'b00) begin
         tests_failed++;
         $display("FAIL repl_errs got %b exp %b", {overflow, underflow}, 2'b00);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         step(STACK_PUSH, 8'(8'hA0 + i), 1'b0);
      end
      tests_run++;
      if (count !== 4'd4 || top_data !== 8'hA3) begin
         tests_failed++;
         $display("FAIL pre_reset got cnt=%0d top=%h exp cnt=4 top=A3", count, top_data);
      end
      // Assert reset mid-cycle (step leaves us 1 ns past a rising edge).
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (count !== 4'd0 || stack_flags !== 2'b01 || top_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL async_reset got cnt=%0d flags=%b top=%h exp cnt=0 flags=01 top=00",
                  count, stack_flags, top_data);
      end
      @(negedge clk);
      rst = 1'b1;
      step(STACK_PUSH, 8'h77, 1'b0);
      tests_run++;
      if (count !== 4'd1 || top_data !== 8'h77) begin
         tests_failed++;
         $display("FAIL post_reset_push got cnt=%0d top=%h exp cnt=1 top=77",
                  count, top_data);
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_replace();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_call_stack
